// File: rtl/issue_ctrl_if.sv
// issue_ctrl_if: decoder, execute, load-retire and status signals of the issue stage.
// The slave modport is the issue stage's view; the master modport is its surroundings.
`ifndef ZONE_RANGE
`define ZONE_RANGE 1:0
`define ZONE_REGFILE 2'd0
`define ZONE_LOADQ 2'd1
`define ZONE_STOREQ 2'd2
`endif
interface issue_ctrl_if #(parameter int C_PAYLOAD_W = 64);
  logic ids_valid_i;
  logic ids_ready_o;
  logic ids_ins_err_i;
  logic ids_csr_access_i;
  logic [`ZONE_RANGE] ids_zone_i;
  logic ids_regd_wr_i;
  logic [4:0] ids_regd_addr_i;
  logic ids_regs1_rd_i;
  logic [4:0] ids_regs1_addr_i;
  logic ids_regs2_rd_i;
  logic [4:0] ids_regs2_addr_i;
  logic [C_PAYLOAD_W-1:0] ids_payload_i;
  logic exs_valid_o;
  logic exs_ready_i;
  logic [`ZONE_RANGE] exs_zone_o;
  logic [4:0] exs_regd_addr_o;
  logic exs_err_o;
  logic [C_PAYLOAD_W-1:0] exs_payload_o;
  logic lq_ret_i;
  logic [4:0] lq_ret_addr_i;
  logic flush_i;
  logic [3:0] lq_pend_cnt_o;
  logic drained_o;
  logic [31:0] stall_cnt_o;
  modport slave(
    input ids_valid_i, ids_ins_err_i, ids_csr_access_i, ids_zone_i, ids_regd_wr_i, ids_regd_addr_i,
    input ids_regs1_rd_i, ids_regs1_addr_i, ids_regs2_rd_i, ids_regs2_addr_i, ids_payload_i,
    input exs_ready_i, lq_ret_i, lq_ret_addr_i, flush_i,
    output ids_ready_o, exs_valid_o, exs_zone_o, exs_regd_addr_o, exs_err_o, exs_payload_o,
    output lq_pend_cnt_o, drained_o, stall_cnt_o
  );
  modport master(
    output ids_valid_i, ids_ins_err_i, ids_csr_access_i, ids_zone_i, ids_regd_wr_i, ids_regd_addr_i,
    output ids_regs1_rd_i, ids_regs1_addr_i, ids_regs2_rd_i, ids_regs2_addr_i, ids_payload_i,
    output exs_ready_i, lq_ret_i, lq_ret_addr_i, flush_i,
    input ids_ready_o, exs_valid_o, exs_zone_o, exs_regd_addr_o, exs_err_o, exs_payload_o,
    input lq_pend_cnt_o, drained_o, stall_cnt_o
  );
endinterface

// File: rtl/issue_ctrl.sv
// issue_ctrl: single-slot issue stage with a load scoreboard, an in-flight load cap,
// and CSR/error serialisation behind a full load drain.
module issue_ctrl #(
  parameter int C_PAYLOAD_W = 64,
  parameter int C_MAX_LOADS = 4
) (
  input logic clk_i,
  input logic resetb_i,
  issue_ctrl_if.slave io
);
  logic valid_q, valid_d, err_q, err_d;
  logic [`ZONE_RANGE] zone_q, zone_d;
  logic [4:0] rd_q, rd_d;
  logic [C_PAYLOAD_W-1:0] payload_q, payload_d;
  logic [31:0] pend_q, pend_d, stall_q, stall_d, ret_mask, busy;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] cnt_eff;
  logic slot_ld, ret_v, hazard, ok, ready, accept, fire, fire_ld;
  always_comb begin
    slot_ld = valid_q & (zone_q == `ZONE_LOADQ);
    ret_v = io.lq_ret_i & (cnt_q != 4'd0);
    ret_mask = io.lq_ret_i ? 32'd1 << io.lq_ret_addr_i : 32'd0;
    busy = ((pend_q & ~ret_mask) | (slot_ld ? 32'd1 << rd_q : 32'd0)) & ~32'd1;
    hazard = (io.ids_regs1_rd_i & busy[io.ids_regs1_addr_i]) |
             (io.ids_regs2_rd_i & busy[io.ids_regs2_addr_i]) |
             (io.ids_regd_wr_i & busy[io.ids_regd_addr_i]);
    cnt_eff = {1'b0, cnt_q} + {4'd0, slot_ld} - {4'd0, ret_v};
    ok = ~hazard & ~((io.ids_zone_i == `ZONE_LOADQ) & (cnt_eff >= 5'(C_MAX_LOADS))) &
         ~((io.ids_csr_access_i | io.ids_ins_err_i) & ((cnt_eff != 5'd0) | valid_q));
    ready = resetb_i & ~io.flush_i & ok & (~valid_q | io.exs_ready_i);
    accept = io.ids_valid_i & ready;
    fire = valid_q & io.exs_ready_i & ~io.flush_i;
    fire_ld = fire & slot_ld;
    valid_d = accept | (valid_q & ~fire & ~io.flush_i);
    err_d = accept ? io.ids_ins_err_i : err_q;
    zone_d = accept ? io.ids_zone_i : zone_q;
    rd_d = accept ? io.ids_regd_addr_i : rd_q;
    payload_d = accept ? io.ids_payload_i : payload_q;
    pend_d = ((pend_q & ~ret_mask) | (fire_ld ? 32'd1 << rd_q : 32'd0)) & ~32'd1;
    cnt_d = cnt_q + {3'd0, fire_ld} - {3'd0, ret_v};
    stall_d = stall_q + {31'd0, io.ids_valid_i & ~ready & ~io.flush_i & ~&stall_q};
  end
  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      valid_q <= 1'b0;
      err_q <= 1'b0;
      zone_q <= `ZONE_REGFILE;
      rd_q <= 5'd0;
      payload_q <= '0;
      pend_q <= 32'd0;
      cnt_q <= 4'd0;
      stall_q <= 32'd0;
    end else begin
      valid_q <= valid_d;
      err_q <= err_d;
      zone_q <= zone_d;
      rd_q <= rd_d;
      payload_q <= payload_d;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      stall_q <= stall_d;
    end
  end
  assign io.ids_ready_o = ready;
  assign io.exs_valid_o = valid_q;
  assign io.exs_zone_o = zone_q;
  assign io.exs_regd_addr_o = rd_q;
  assign io.exs_err_o = err_q;
  assign io.exs_payload_o = payload_q;
  assign io.lq_pend_cnt_o = cnt_q;
  assign io.drained_o = (cnt_q == 4'd0) & ~slot_ld;
  assign io.stall_cnt_o = stall_q;
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed scenarios against a rule-level model of the issue stage,
// compared every cycle, plus hand-computed literal expectations.
`ifndef ZONE_RANGE
`define ZONE_RANGE 1:0
`define ZONE_REGFILE 2'd0
`define ZONE_LOADQ 2'd1
`define ZONE_STOREQ 2'd2
`endif
module tb_issue_ctrl;
  localparam int C_MAX = 4;
  logic clk = 1'b0;
  logic resetb;
  int checks = 0;
  int failures = 0;
  int pl_n = 0;
  issue_ctrl_if #(.C_PAYLOAD_W(64)) bus();
  issue_ctrl #(.C_PAYLOAD_W(64), .C_MAX_LOADS(C_MAX)) dut (.clk_i(clk), .resetb_i(resetb), .io(bus));
  always #5 clk = ~clk;
  bit m_init = 1'b0;
  bit m_valid, m_err;
  logic [1:0] m_zone;
  logic [4:0] m_rd;
  logic [63:0] m_pl;
  bit m_pend [32];
  int m_cnt;
  logic [31:0] m_stall;
  function automatic bit m_slot_ld();
    return m_valid && m_zone == `ZONE_LOADQ;
  endfunction
  function automatic bit m_busy(input logic [4:0] r);
    return r != 5'd0 && ((m_pend[r] && !(bus.lq_ret_i && bus.lq_ret_addr_i == r)) || (m_slot_ld() && m_rd == r));
  endfunction
  function automatic bit m_ready();
    int ce;
    if (!resetb || bus.flush_i || (m_valid && !bus.exs_ready_i)) return 1'b0;
    if ((bus.ids_regs1_rd_i && m_busy(bus.ids_regs1_addr_i)) || (bus.ids_regs2_rd_i && m_busy(bus.ids_regs2_addr_i)) ||
        (bus.ids_regd_wr_i && m_busy(bus.ids_regd_addr_i))) return 1'b0;
    ce = m_cnt + (m_slot_ld() ? 1 : 0) - ((bus.lq_ret_i && m_cnt > 0) ? 1 : 0);
    if (bus.ids_zone_i == `ZONE_LOADQ && ce >= C_MAX) return 1'b0;
    if ((bus.ids_csr_access_i || bus.ids_ins_err_i) && (ce != 0 || m_valid)) return 1'b0;
    return 1'b1;
  endfunction
  function automatic bit m_fire_ld();
    return m_valid && bus.exs_ready_i && !bus.flush_i && m_slot_ld();
  endfunction
  always @(posedge clk) begin
    if (!resetb) begin
      m_init <= 1'b1;
      m_valid <= 1'b0;
      m_err <= 1'b0;
      m_zone <= `ZONE_REGFILE;
      m_rd <= 5'd0;
      m_pl <= 64'd0;
      for (int i = 0; i < 32; i++) m_pend[i] <= 1'b0;
      m_cnt <= 0;
      m_stall <= 32'd0;
    end else begin
      if (bus.lq_ret_i) m_pend[bus.lq_ret_addr_i] <= 1'b0;
      if (m_fire_ld() && m_rd != 5'd0) m_pend[m_rd] <= 1'b1;
      m_cnt <= m_cnt + (m_fire_ld() ? 1 : 0) - ((bus.lq_ret_i && m_cnt > 0) ? 1 : 0);
      if (bus.flush_i) m_valid <= 1'b0;
      else if (bus.ids_valid_i && m_ready()) begin
        m_valid <= 1'b1;
        m_err <= bus.ids_ins_err_i;
        m_zone <= bus.ids_zone_i;
        m_rd <= bus.ids_regd_addr_i;
        m_pl <= bus.ids_payload_i;
      end else if (m_valid && bus.exs_ready_i) m_valid <= 1'b0;
      if (bus.ids_valid_i && !m_ready() && !bus.flush_i && m_stall != 32'hFFFF_FFFF) m_stall <= m_stall + 32'd1;
    end
  end
  task automatic cmp(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) if (m_init) begin
    cmp("ids_ready", 64'(bus.ids_ready_o), 64'(m_ready()));
    cmp("exs_valid", 64'(bus.exs_valid_o), 64'(m_valid));
    cmp("exs_zone", 64'(bus.exs_zone_o), 64'(m_zone));
    cmp("exs_rd", 64'(bus.exs_regd_addr_o), 64'(m_rd));
    cmp("exs_err", 64'(bus.exs_err_o), 64'(m_err));
    cmp("exs_payload", bus.exs_payload_o, m_pl);
    cmp("pend_cnt", 64'(bus.lq_pend_cnt_o), 64'(m_cnt));
    cmp("drained", 64'(bus.drained_o), 64'(m_cnt == 0 && !m_slot_ld()));
    cmp("stall_cnt", 64'(bus.stall_cnt_o), 64'(m_stall));
  end
  task automatic drv(input bit v, input logic [1:0] z, input bit wr, input logic [4:0] rd, input bit r1, input logic [4:0] s1,
                     input bit r2, input logic [4:0] s2, input bit csr, input bit err);
    pl_n++;
    bus.ids_valid_i = v;
    bus.ids_zone_i = z;
    bus.ids_regd_wr_i = wr;
    bus.ids_regd_addr_i = rd;
    bus.ids_regs1_rd_i = r1;
    bus.ids_regs1_addr_i = s1;
    bus.ids_regs2_rd_i = r2;
    bus.ids_regs2_addr_i = s2;
    bus.ids_csr_access_i = csr;
    bus.ids_ins_err_i = err;
    bus.ids_payload_i = 64'hA5A5_0000_0000_0000 | 64'(pl_n);
  endtask
  task automatic ld(input logic [4:0] rd);
    drv(1'b1, `ZONE_LOADQ, 1'b1, rd, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask
  task automatic alu(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
    drv(1'b1, `ZONE_REGFILE, 1'b1, rd, 1'b1, s1, 1'b1, s2, 1'b0, 1'b0);
  endtask
  task automatic idle();
    drv(1'b0, `ZONE_REGFILE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask
  task automatic ret(input bit v, input logic [4:0] a);
    bus.lq_ret_i = v;
    bus.lq_ret_addr_i = a;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    resetb = 1'b0;
    bus.exs_ready_i = 1'b1;
    bus.flush_i = 1'b0;
    ret(1'b0, 5'd0);
    alu(5'd6, 5'd5, 5'd0);
    repeat (2) begin
      cyc(); #1;
      cmp("rst_ready", 64'(bus.ids_ready_o), 64'd0);
      cmp("rst_valid", 64'(bus.exs_valid_o), 64'd0);
      cmp("rst_cnt", 64'(bus.lq_pend_cnt_o), 64'd0);
      cmp("rst_stall", 64'(bus.stall_cnt_o), 64'd0);
    end
    resetb = 1'b1;
    ld(5'd5);
    cyc(); alu(5'd6, 5'd5, 5'd0); #1;
    cmp("raw_slot_stall", 64'(bus.ids_ready_o), 64'd0);
    cyc(); #1;
    cmp("raw_pend_stall", 64'(bus.ids_ready_o), 64'd0);
    cmp("stall_one", 64'(bus.stall_cnt_o), 64'd1);
    cyc(); ret(1'b1, 5'd5); #1;
    cmp("ret_bypass_ready", 64'(bus.ids_ready_o), 64'd1);
    cmp("stall_two", 64'(bus.stall_cnt_o), 64'd2);
    cyc(); idle(); ret(1'b0, 5'd0); #1;
    cmp("add_issued", 64'(bus.exs_valid_o), 64'd1);
    cmp("add_rd", 64'(bus.exs_regd_addr_o), 64'd6);
    cmp("cnt_after_ret", 64'(bus.lq_pend_cnt_o), 64'd0);
    for (int i = 1; i <= 5; i++) begin
      cyc(); ld(5'(i));
    end
    #1;
    cmp("cap_stall", 64'(bus.ids_ready_o), 64'd0);
    cmp("cap_cnt3", 64'(bus.lq_pend_cnt_o), 64'd3);
    cyc(); ret(1'b1, 5'd1); #1;
    cmp("cap_ret_ready", 64'(bus.ids_ready_o), 64'd1);
    cyc(); idle(); ret(1'b0, 5'd0);
    for (int i = 2; i <= 5; i++) begin
      cyc(); ret(1'b1, 5'(i));
    end
    cyc(); ret(1'b0, 5'd0); #1;
    cmp("drain_cnt", 64'(bus.lq_pend_cnt_o), 64'd0);
    cmp("drain_flag", 64'(bus.drained_o), 64'd1);
    ld(5'd7);
    cyc(); drv(1'b1, `ZONE_REGFILE, 1'b1, 5'd8, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0); #1;
    cmp("csr_slot_stall", 64'(bus.ids_ready_o), 64'd0);
    cyc(); #1;
    cmp("csr_cnt_stall", 64'(bus.ids_ready_o), 64'd0);
    cmp("csr_not_drained", 64'(bus.drained_o), 64'd0);
    cyc(); ret(1'b1, 5'd7); #1;
    cmp("csr_ret_ready", 64'(bus.ids_ready_o), 64'd1);
    cyc(); idle(); ret(1'b0, 5'd0); #1;
    cmp("csr_issued", 64'(bus.exs_valid_o), 64'd1);
    cmp("csr_drained", 64'(bus.drained_o), 64'd1);
    cyc(); bus.exs_ready_i = 1'b0; ld(5'd9);
    cyc(); alu(5'd10, 5'd9, 5'd9); bus.flush_i = 1'b1; #1;
    cmp("flush_slot_held", 64'(bus.exs_valid_o), 64'd1);
    cmp("flush_ld_not_drained", 64'(bus.drained_o), 64'd0);
    cmp("flush_ready", 64'(bus.ids_ready_o), 64'd0);
    cyc(); bus.flush_i = 1'b0; bus.exs_ready_i = 1'b1; #1;
    cmp("flush_valid", 64'(bus.exs_valid_o), 64'd0);
    cmp("flush_cnt", 64'(bus.lq_pend_cnt_o), 64'd0);
    cmp("flush_x9_free", 64'(bus.ids_ready_o), 64'd1);
    cyc(); idle();
    ld(5'd0);
    cyc(); alu(5'd11, 5'd0, 5'd0); #1;
    cmp("x0_no_stall", 64'(bus.ids_ready_o), 64'd1);
    cyc(); idle(); #1;
    cmp("x0_cnt1", 64'(bus.lq_pend_cnt_o), 64'd1);
    ret(1'b1, 5'd0);
    cyc(); #1;
    cmp("x0_ret_cnt0", 64'(bus.lq_pend_cnt_o), 64'd0);
    cyc(); ret(1'b0, 5'd0); #1;
    cmp("ret_at_zero", 64'(bus.lq_pend_cnt_o), 64'd0);
    ld(5'd3);
    cyc(); drv(1'b1, `ZONE_REGFILE, 1'b0, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); #1;
    cmp("err_slot_stall", 64'(bus.ids_ready_o), 64'd0);
    cyc(); #1;
    cmp("err_cnt_stall", 64'(bus.ids_ready_o), 64'd0);
    cyc(); ret(1'b1, 5'd3); #1;
    cmp("err_ret_ready", 64'(bus.ids_ready_o), 64'd1);
    cyc(); idle(); ret(1'b0, 5'd0); #1;
    cmp("err_flag", 64'(bus.exs_err_o), 64'd1);
    cyc(); ld(5'd4);
    cyc(); idle();
    cyc(); #1;
    cmp("pre_reset_cnt", 64'(bus.lq_pend_cnt_o), 64'd1);
    resetb = 1'b0;
    cyc(); #1;
    cmp("mid_reset_cnt", 64'(bus.lq_pend_cnt_o), 64'd0);
    cmp("mid_reset_valid", 64'(bus.exs_valid_o), 64'd0);
    resetb = 1'b1;
    cyc();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
